btn_debounce: RTL

- Input-side counterpart to the LED drivers: conditions a raw, bouncing board push-button or slide switch into clean, clock-aligned control signals.
- Synchronises the pin into `clk`, debounces it with a cycle counter and a four-state FSM, and produces:
  - a stable level;
  - single-cycle press and release strobes;
  - a long-press strobe;
  - a wrapping press counter.
- One instance per button, sitting between the top-level pin and the user logic.

---
 rtl/btn_debounce_if.sv | 24 ++
 rtl/btn_debounce.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_if.sv
// Button pin and conditioned outputs between the debouncer and user logic.
// master = the debouncer, slave = the logic that drives the pin and consumes the strobes.
interface btn_debounce_if #(
    parameter int CNT_W = 8
);
    logic             btn_in;
    logic             btn_level;
    logic             press;
    // The release strobe cannot be called "release": that is a reserved word in SystemVerilog.
    logic             release_stb;
    logic             long_press;
    logic             held;
    logic [CNT_W-1:0] press_count;

    modport master (
        input  btn_in,
        output btn_level, press, release_stb, long_press, held, press_count
    );

    modport slave (
        output btn_in,
        input  btn_level, press, release_stb, long_press, held, press_count
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, counter-based debounce FSM,
// press/release/long-press strobes and a wrapping press counter.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter bit ACTIVE_HIGH     = 1'b1,
    parameter int CNT_W           = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_debounce_if.master bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int LONG_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    // Firing when the count is about to become LONG_CYCLES-1 puts long_press
    // exactly DEBOUNCE_CYCLES+LONG_CYCLES edges after the pin change is captured.
    localparam logic [LONG_W-1:0] LONG_ARM = LONG_W'(LONG_CYCLES - 2);

    typedef enum logic [1:0] {
        RELEASED,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } state_t;

    logic raw;
    logic s1, s2;

    state_t           state, state_nxt;
    logic [DB_W-1:0]   db_cnt, db_nxt;
    logic [LONG_W-1:0] long_cnt, long_nxt;
    logic              fired, fired_nxt;
    logic              level, level_nxt;
    logic              held, held_nxt;
    logic              press, press_nxt;
    logic              rel, rel_nxt;
    logic              long_p, long_p_nxt;
    logic [CNT_W-1:0]  count, count_nxt;

    assign raw = ACTIVE_HIGH ? bus.btn_in : ~bus.btn_in;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (s2 must see the old s1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            long_cnt <= '0;
            fired    <= 1'b0;
            level    <= 1'b0;
            held     <= 1'b0;
            press    <= 1'b0;
            rel      <= 1'b0;
            long_p   <= 1'b0;
            count    <= '0;
        end else begin
            db_cnt   <= db_nxt;
            long_cnt <= long_nxt;
            fired    <= fired_nxt;
            level    <= level_nxt;
            held     <= held_nxt;
            press    <= press_nxt;
            rel      <= rel_nxt;
            long_p   <= long_p_nxt;
            count    <= count_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned and infer a latch; strobes default low.
        state_nxt  = state;
        db_nxt     = db_cnt;
        long_nxt   = long_cnt;
        fired_nxt  = fired;
        level_nxt  = level;
        held_nxt   = held;
        count_nxt  = count;
        press_nxt  = 1'b0;
        rel_nxt    = 1'b0;
        long_p_nxt = 1'b0;

        // Long-press timing keeps running through a pending (possibly rejected) release.
        if ((state == PRESSED || state == DB_RELEASE) && !fired) begin
            long_nxt = long_cnt + LONG_W'(1);
            if (long_cnt == LONG_ARM) begin
                long_p_nxt = 1'b1;
                held_nxt   = 1'b1;
                fired_nxt  = 1'b1;
            end
        end

        case (state)
            RELEASED: begin
                if (s2) begin
                    state_nxt = DB_PRESS;
                    db_nxt    = DB_ONE;
                end
            end
            DB_PRESS: begin
                if (!s2) begin
                    state_nxt = RELEASED;
                    db_nxt    = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = PRESSED;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                    count_nxt = count + CNT_W'(1);
                    long_nxt  = '0;
                    fired_nxt = 1'b0;
                    db_nxt    = '0;
                end else begin
                    db_nxt = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_nxt = DB_RELEASE;
                    db_nxt    = DB_ONE;
                end
            end
            DB_RELEASE: begin
                if (s2) begin
                    state_nxt = PRESSED;
                    db_nxt    = '0;
                end else if (db_cnt == DB_LAST) begin
                    // Overrides a long-press firing on this same edge: held stays low.
                    state_nxt = RELEASED;
                    level_nxt = 1'b0;
                    held_nxt  = 1'b0;
                    rel_nxt   = 1'b1;
                    db_nxt    = '0;
                end else begin
                    db_nxt = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
                db_nxt    = '0;
            end
        endcase
    end

    assign bus.btn_level   = level;
    assign bus.press       = press;
    assign bus.release_stb = rel;
    assign bus.long_press  = long_p;
    assign bus.held        = held;
    assign bus.press_count = count;

endmodule
